// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC sequencer plus the IF/ID pipeline register.
// Handles stall, flush and taken-branch/jump redirects; no delay slot.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
);

    // if_id_valid qualifies the IF/ID contents every cycle: 1 = real
    // instruction for decode, 0 = bubble. There is no back-pressure
    // handshake; stall freezes the register instead.

    logic [31:0] pc_plus4;
    logic [31:0] jump_addr;
    logic [31:0] next_pc;
    logic        take_branch;
    logic        take_jump;
    logic        redirect;

    assign pc_plus4    = pc + 32'd4;
    assign jump_addr   = {if_id_pc_plus4[31:28], jump_index, 2'b00};
    // Redirect requests only count when ID holds a real instruction.
    assign take_branch = branch_taken & if_id_valid;
    assign take_jump   = jump & if_id_valid;
    assign redirect    = take_branch | take_jump;
    assign imem_addr   = pc;

    always_comb begin
        next_pc = pc_plus4;
        if (take_branch) begin
            next_pc = {branch_target[31:2], 2'b00};
        end else if (take_jump) begin
            next_pc = jump_addr;
        end else if (stall) begin
            next_pc = pc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc             <= {RESET_PC[31:2], 2'b00};
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else begin
            pc <= next_pc;
            // A redirect overrides stall so the hazard logic never loses it.
            if (redirect || flush) begin
                if_id_instr    <= NOP_INSTR;
                if_id_pc_plus4 <= 32'd0;
                if_id_valid    <= 1'b0;
            end else if (!stall) begin
                if_id_instr    <= imem_instr;
                if_id_pc_plus4 <= pc_plus4;
                if_id_valid    <= 1'b1;
            end
        end
    end

endmodule
